// File: rtl/div_seq_ctrl.sv
// Iterative restoring divider with its sequencing FSM for DIV/DIVU.
// Ports: div_* request (valid/ready), res_* result (valid/ready), div_flush cancel, busy interlock.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    input  logic             div_flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_quot,
    output logic [WIDTH-1:0] res_rem,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             sgnq_q, sgnq_d;
    logic             sgnr_q, sgnr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] rquot_q, rquot_d;
    logic [WIDTH-1:0] rrem_q, rrem_d;

    logic             accept;
    logic             neg_dd, neg_dv;
    logic [WIDTH-1:0] dd_mag, dv_mag;
    logic [WIDTH:0]   shl, trial;
    logic             fits;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign neg_dd = div_signed & div_dividend[WIDTH-1];
    assign neg_dv = div_signed & div_divisor[WIDTH-1];
    assign dd_mag = neg_dd ? -div_dividend : div_dividend;
    assign dv_mag = neg_dv ? -div_divisor : div_divisor;

    // Quotient register doubles as the dividend shift source.
    assign shl      = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shl - {1'b0, dvs_q};
    assign fits     = ~trial[WIDTH];
    assign rem_step = fits ? trial[WIDTH-1:0] : shl[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], fits};

    // Divide-by-zero bypasses sign fix-up and returns the raw dividend.
    assign quot_fix = dz_q ? {WIDTH{1'b1}}
                    : (sgnq_q ? -quo_step : quo_step);
    assign rem_fix  = dz_q ? dvd_q
                    : (sgnr_q ? -rem_step : rem_step);

    assign div_ready = ((state_q == S_IDLE) |
                        ((state_q == S_DONE) & res_ready)) & ~div_flush;
    assign accept    = div_valid & div_ready;
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res_quot  = rquot_q;
    assign res_rem   = rrem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        dz_d    = dz_q;
        rquot_d = rquot_q;
        rrem_d  = rrem_q;
        if (div_flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d = S_CALC;
            cnt_d   = CW'(WIDTH - 1);
            rem_d   = '0;
            quo_d   = dd_mag;
            dvs_d   = dv_mag;
            dvd_d   = div_dividend;
            sgnq_d  = neg_dd ^ neg_dv;
            sgnr_d  = neg_dd;
            dz_d    = (div_divisor == '0);
        end else begin
            unique case (state_q)
                S_CALC: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        rquot_d = quot_fix;
                        rrem_d  = rem_fix;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) state_d = S_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            dz_q    <= 1'b0;
            rquot_q <= '0;
            rrem_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            dz_q    <= dz_d;
            rquot_q <= rquot_d;
            rrem_q  <= rrem_d;
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed corner cases plus randomized traffic.
// Expected results come from plain integer division in a reference function.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         div_valid = 1'b0;
    logic         div_signed = 1'b0;
    logic         div_flush = 1'b0;
    logic         res_ready = 1'b0;
    logic [W-1:0] div_dividend = '0;
    logic [W-1:0] div_divisor = '0;
    logic         div_ready;
    logic         res_valid;
    logic         busy;
    logic [W-1:0] res_quot;
    logic [W-1:0] res_rem;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_valid    (div_valid),
        .div_ready    (div_ready),
        .div_signed   (div_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_flush    (div_flush),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_quot     (res_quot),
        .res_rem      (res_rem),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           acc;
        bit           seen;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   acc_evt = 1'b0;

    function automatic void chk(input string n, input logic [31:0] a,
                                input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
        end
    endfunction

    function automatic void model(input bit sg, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] q,
                                  output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Monitor: flush/reset cancel pending work, results checked while valid.
    always @(negedge clk) begin
        exp_t e;
        acc_evt = 1'b0;
        if (!resetn) begin
            sbq.delete();
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end else if (div_flush) begin
            sbq.delete();
        end else begin
            if (res_valid) begin
                chk("result_pending", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    if (!sbq[0].seen) begin
                        chk("latency", 32'(cyc - sbq[0].acc), 32'(W + 1));
                        sbq[0].seen = 1'b1;
                    end
                    chk("quot", res_quot, sbq[0].q);
                    chk("rem", res_rem, sbq[0].r);
                    if (res_ready) void'(sbq.pop_front());
                end
            end
            if (div_valid && div_ready) begin
                model(div_signed, div_dividend, div_divisor, e.q, e.r);
                e.acc  = cyc;
                e.seen = 1'b0;
                sbq.push_back(e);
                acc_evt = 1'b1;
            end
        end
    end

    task automatic scramble();
        div_signed   = 1'($urandom);
        div_dividend = $urandom;
        div_divisor  = $urandom;
    endtask

    task automatic issue(input bit sg, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int n = 0;
        div_signed   = sg;
        div_dividend = a;
        div_divisor  = b;
        div_valid    = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc_evt && n < 300);
        chk("accept_timeout", 32'(acc_evt), 32'd1);
        div_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_op(input bit sg, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        issue(sg, a, b);
        wait_idle();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int nops;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_div_ready", 32'(div_ready), 32'd1);
        chk("rst_quot", res_quot, 32'd0);
        chk("rst_rem", res_rem, 32'd0);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;

        do_op(1'b0, 32'd100, 32'd7);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        do_op(1'b0, 32'h1234, 32'd0);
        do_op(1'b1, 32'hFFFF_FF00, 32'd0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1);

        // Flush mid-calculation, cnt == 10 after the 21st step.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (21) @(posedge clk);
        #1 div_flush = 1'b1;
        @(posedge clk);
        #1 div_flush = 1'b0;
        @(negedge clk);
        chk("flush_res_valid", 32'(res_valid), 32'd0);
        chk("flush_div_ready", 32'(div_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        do_op(1'b0, 32'd9, 32'd3);

        // Back-pressure then a back-to-back accept on the handshake.
        res_ready = 1'b0;
        issue(1'b1, 32'hFFFF_FC18, 32'd7);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_valid_timeout", 32'(res_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_div_ready", 32'(div_ready), 32'd0);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        res_ready    = 1'b1;
        div_valid    = 1'b1;
        div_signed   = 1'b0;
        div_dividend = 32'd12345;
        div_divisor  = 32'd100;
        @(negedge clk);
        chk("b2b_div_ready", 32'(div_ready), 32'd1);
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        scramble();
        wait_idle();

        // Asynchronous reset pulse during calculation.
        issue(1'b0, 32'd55555, 32'd13);
        repeat (10) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("async_res_valid", 32'(res_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(div_ready), 32'd1);
        @(posedge clk);
        #1;
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2);

        // Randomized traffic with random back-pressure and rare flushes.
        nops = 0;
        for (int c = 0; c < 20000 && nops < 300; c++) begin
            @(posedge clk);
            #1;
            res_ready = ($urandom_range(0, 3) != 0);
            div_flush = ($urandom_range(0, 199) == 0);
            if (div_valid && acc_evt) begin
                div_valid = 1'b0;
                scramble();
                nops++;
            end
            if (!div_valid && $urandom_range(0, 3) == 0) begin
                div_valid    = 1'b1;
                div_signed   = 1'($urandom);
                div_dividend = pick();
                div_divisor  = pick();
            end
        end
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        div_flush = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        chk("random_ops_done", 32'(nops), 32'd300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
